// File: rtl/uart_arb_pkg.sv
// Shared state encoding, tag prefix and frame-length helper for uart_tx_arbiter.
// The TAG_* states are only reachable when UART_TX_ARB_TAG_EN is defined.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_FRAME     = 3'd2,
      ST_TAG_SEND  = 3'd3,
      ST_TAG_FRAME = 3'd4
   } arb_state_e;

   localparam logic [3:0] TAG_PREFIX = 4'hA;

   // Clocks occupied by one UART frame plus the trailing idle gap.
   function automatic int frame_cycles(input int clock, input int baud, input int data,
                                       input int stop, input int gap);
      return (clock / baud) * (data + 1 + stop) + gap;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with wrap-around
// and returns a one-hot grant, its encoded index and an any-request flag.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
   output logic                       any_o
);

   localparam int IW = $clog2(NUM_REQ);

   always_comb begin
      logic [IW-1:0] idx;
      // NOTE: every output gets a default before the search loop so no path infers a latch.
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      idx         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(ptr_i) + k) % NUM_REQ);
         if (!any_o && req_i[idx]) begin
            any_o       = 1'b1;
            grant_o     = '0;
            grant_o[idx] = 1'b1;
            grant_idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; frame timing is self-generated.
// Define UART_TX_ARB_TAG_EN to precede each payload byte with a {4'hA, id} tag frame.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int CLOCK      = 50000000,
   parameter int BAUD       = 9600,
   parameter int DATA       = 8,
   parameter int STOP       = 1,
   parameter int GAP_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA-1:0]    req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       uart_new_data,
   output logic [DATA-1:0]            uart_data_in,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int            IW           = $clog2(NUM_REQ);
   localparam int            FRAME_CYCLES = frame_cycles(CLOCK, BAUD, DATA, STOP, GAP_CYCLES);
   localparam int            TW           = $clog2(FRAME_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD   = TW'(FRAME_CYCLES - 1);

   arb_state_e      state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   grant_id_q, grant_id_d;
   logic [DATA-1:0] data_q, data_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;
   logic [DATA-1:0]    req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA +: DATA];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .any_o       (arb_any)
   );

`ifdef UART_TX_ARB_TAG_EN
   logic [DATA-1:0] payload_q, payload_d;

   // NOTE: payload_q has no reset; it is always written on accept before it is read.
   always_ff @(posedge clk) begin
      payload_q <= payload_d;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         grant_id_q <= '0;
         data_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         timer_q    <= timer_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         data_q     <= data_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      data_d     = data_q;
`ifdef UART_TX_ARB_TAG_EN
      payload_d  = payload_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               ptr_d      = arb_idx;
               grant_id_d = arb_idx;
`ifdef UART_TX_ARB_TAG_EN
               payload_d  = req_bytes[arb_idx];
               data_d     = DATA'({TAG_PREFIX, 4'(arb_idx)});
               state_d    = ST_TAG_SEND;
`else
               data_d     = req_bytes[arb_idx];
               state_d    = ST_SEND;
`endif
            end
         end
         ST_SEND: begin
            timer_d = TIMER_LOAD;
            state_d = ST_FRAME;
         end
         ST_FRAME: begin
            if (timer_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
`ifdef UART_TX_ARB_TAG_EN
         ST_TAG_SEND: begin
            timer_d = TIMER_LOAD;
            state_d = ST_TAG_FRAME;
         end
         ST_TAG_FRAME: begin
            // The payload replaces the tag on the same edge that enters SEND.
            if (timer_q == '0) begin
               data_d  = payload_q;
               state_d = ST_SEND;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs; req_ready is held low while rst is asserted so no producer sees a false accept.
   always_comb begin
      req_ready     = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
      uart_new_data = (state_q == ST_SEND) || (state_q == ST_TAG_SEND);
      busy          = (state_q != ST_IDLE);
   end

   assign uart_data_in = data_q;
   assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written corner
// sequences, a UART loopback decoder and a randomized run against a cycle-count model.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int CLOCK      = 1000;
   localparam int BAUD       = 100;
   localparam int DATA       = 8;
   localparam int STOP       = 1;
   localparam int GAP_CYCLES = 4;
   localparam int BIT_CYCLES = CLOCK / BAUD;
   localparam int FRAME      = BIT_CYCLES * (DATA + 1 + STOP) + GAP_CYCLES;
`ifdef UART_TX_ARB_TAG_EN
   localparam bit TAG = 1'b1;
`else
   localparam bit TAG = 1'b0;
`endif
   // Accept-to-accept period: accept, SEND, FRAME (and the tag pair when enabled).
   localparam int PERIOD = TAG ? 2 * (FRAME + 1) + 1 : FRAME + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        uart_new_data;
   logic [7:0]  uart_data_in;
   logic        busy;
   logic [1:0]  grant_id;

   int n_vec = 0;
   int n_bad = 0;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .CLOCK      (CLOCK),
      .BAUD       (BAUD),
      .DATA       (DATA),
      .STOP       (STOP),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .uart_new_data (uart_new_data),
      .uart_data_in  (uart_data_in),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   // UART loopback: loads data_in one cycle after new_data, shifts LSB first.
   logic       nd_seen = 1'b0;
   logic [9:0] tx_sr   = '1;
   int         tx_bits = 0;
   int         tx_cnt  = 0;
   logic       tx_line;
   logic [7:0] rx_q [$];

   always @(posedge clk) begin
      if (rst) begin
         nd_seen <= 1'b0;
         tx_bits <= 0;
      end else begin
         nd_seen <= uart_new_data;
         if (nd_seen) begin
            tx_sr   <= {1'b1, uart_data_in, 1'b0};
            tx_bits <= 10;
            tx_cnt  <= 0;
         end else if (tx_bits != 0) begin
            if (tx_cnt == BIT_CYCLES - 1) begin
               tx_cnt  <= 0;
               tx_sr   <= {1'b1, tx_sr[9:1]};
               tx_bits <= tx_bits - 1;
            end else begin
               tx_cnt <= tx_cnt + 1;
            end
         end
      end
   end

   assign tx_line = (tx_bits != 0) ? tx_sr[0] : 1'b1;

   always begin
      logic [7:0] rx_byte;
      @(negedge tx_line);
      repeat (BIT_CYCLES / 2) @(posedge clk);
      for (int b = 0; b < 8; b++) begin
         repeat (BIT_CYCLES) @(posedge clk);
         #1 rx_byte[b] = tx_line;
      end
      rx_q.push_back(rx_byte);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Tasks start and end at a drive point: right after a falling clock edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 3 * PERIOD; c++) begin
         #1;
         if (!busy) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      check(name, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  ready;
      logic [1:0]  id;
      logic [7:0]  pay;
   } vec_t;

   task automatic apply_vec(input vec_t v, input int n);
      int         bad_hold;
      logic [7:0] tagb;
      logic [7:0] exp_d;
      string      nm;
      bad_hold = 0;
      tagb     = {4'hA, 2'b00, v.id};
      nm       = $sformatf("vec%0d", n);
      req_valid = v.valid;
      req_data  = v.data;
      #1 check({nm, ".ready"}, 32'(req_ready), 32'(v.ready));
      @(negedge clk);
      req_valid = '0;
      #1;
      check({nm, ".pulse"}, 32'(uart_new_data), 32'd1);
      check({nm, ".id"}, 32'(grant_id), 32'(v.id));
      check({nm, ".data"}, 32'(uart_data_in), 32'(TAG ? tagb : v.pay));
      for (int k = 2; k < PERIOD; k++) begin
         @(negedge clk);
         #1;
         exp_d = (TAG && k < FRAME + 2) ? tagb : v.pay;
         if (uart_new_data !== (TAG && k == FRAME + 2) || uart_data_in !== exp_d ||
             busy !== 1'b1 || req_ready !== 4'b0000)
            bad_hold++;
      end
      check({nm, ".hold"}, 32'(bad_hold), 32'd0);
      @(negedge clk);
      #1 check({nm, ".idle"}, 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int last);
      int idx;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (last + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs [8];
      int   acc_cyc [5];
      logic [3:0] acc_rdy [5];
      int   exp_ids [5];
      int   n_acc, bad;
      // Model state for the randomized run.
      int   m_rem, m_since, m_ptr, m_id, w;
      logic [7:0] m_data, m_pay;
      logic [3:0] exp_ready;
      logic       exp_nd;

      // Pointer starts at 3 after reset; each row's expectation follows from the previous grant.
      vecs[0] = '{4'b0100, 32'h115A2233, 4'b0100, 2'd2, 8'h5A};
      vecs[1] = '{4'b1111, 32'hA3A2A1A0, 4'b1000, 2'd3, 8'hA3};
      vecs[2] = '{4'b1111, 32'hB3B2B1B0, 4'b0001, 2'd0, 8'hB0};
      vecs[3] = '{4'b0011, 32'hC3C2C1C0, 4'b0010, 2'd1, 8'hC1};
      vecs[4] = '{4'b0001, 32'hD3D2D1D0, 4'b0001, 2'd0, 8'hD0};
      vecs[5] = '{4'b1010, 32'hE3E2E1E0, 4'b0010, 2'd1, 8'hE1};
      vecs[6] = '{4'b0100, 32'hF3F2F1F0, 4'b0100, 2'd2, 8'hF2};
      vecs[7] = '{4'b1001, 32'h0F0E0D0C, 4'b1000, 2'd3, 8'h0F};
      exp_ids = '{0, 1, 2, 3, 0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.pulse", 32'(uart_new_data), 32'd0);
      check("rst.data", 32'(uart_data_in), 32'd0);
      check("rst.id", 32'(grant_id), 32'd0);
      check("rst.ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table; row 0 is also decoded by the loopback UART
      rx_q.delete();
      for (int i = 0; i < 8; i++) begin
         apply_vec(vecs[i], i);
         if (i == 0) begin
            check("loop.count", 32'(rx_q.size()), 32'(TAG ? 2 : 1));
            for (int j = 0; j < rx_q.size(); j++)
               check($sformatf("loop.byte%0d", j), 32'(rx_q[j]),
                     32'((TAG && j == 0) ? 8'hA2 : 8'h5A));
         end
      end

      // All requesters held valid: strict rotation at the fixed period
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'h03020100;
      n_acc = 0;
      for (int c = 0; c < 6 * PERIOD && n_acc < 5; c++) begin
         #1;
         if (req_ready != 4'b0000) begin
            acc_cyc[n_acc] = c;
            acc_rdy[n_acc] = req_ready;
            n_acc++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      check("rr.count", 32'(n_acc), 32'd5);
      for (int i = 0; i < n_acc; i++) begin
         check($sformatf("rr.grant%0d", i), 32'(acc_rdy[i]), 32'(4'b0001 << exp_ids[i]));
         if (i > 0)
            check($sformatf("rr.gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(PERIOD));
      end
      wait_idle("rr.idle_wait");

      // Reset in the middle of FRAME
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h00000077;
      #1 check("mid.ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = '0;
      repeat (50) @(negedge clk);
      #1 check("mid.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b1010;
      req_data  = 32'h44332211;
      #1;
      check("mid.busy", 32'(busy), 32'd0);
      check("mid.pulse", 32'(uart_new_data), 32'd0);
      check("mid.data", 32'(uart_data_in), 32'd0);
      check("mid.id", 32'(grant_id), 32'd0);
      check("mid.ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("mid.id_after", 32'(grant_id), 32'd1);
      check("mid.pulse_after", 32'(uart_new_data), 32'd1);
      wait_idle("mid.idle_wait");

      // Requester 1 drops and reasserts valid while requester 0 holds the UART
      do_reset();
      req_valid = 4'b0011;
      req_data  = 32'h0000BBAA;
      #1 check("drop.first", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = 4'b0010;
      bad = 0;
      for (int c = 1; c < PERIOD; c++) begin
         if (c == 20) req_valid = 4'b0000;
         if (c == 40) req_valid = 4'b0010;
         #1;
         if (req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd0) bad++;
         @(negedge clk);
      end
      check("drop.blocked", 32'(bad), 32'd0);
      #1 check("drop.turn", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b0001;
      req_data  = 32'h0000BBCC;
      #1;
      check("drop.id", 32'(grant_id), 32'd1);
      check("drop.data", 32'(uart_data_in), 32'(TAG ? 8'hA1 : 8'hBB));
      bad = 0;
      for (int c = 2; c < PERIOD; c++) begin
         @(negedge clk);
         #1;
         if (req_ready !== 4'b0000) bad++;
      end
      check("drop.blocked2", 32'(bad), 32'd0);
      @(negedge clk);
      #1 check("drop.no_dup", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = '0;
      wait_idle("drop.idle_wait");

      // Randomized run against the cycle-count model
      do_reset();
      m_rem = 0; m_since = 0; m_ptr = NUM_REQ - 1; m_id = 0; m_data = '0; m_pay = '0;
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 599) == 0);
         req_valid = (rst || $urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         req_data  = $urandom;
         #1;
         w         = rr_pick(req_valid, m_ptr);
         exp_ready = (m_rem == 0 && w >= 0) ? 4'(4'b0001 << w) : 4'b0000;
         exp_nd    = (m_rem > 0) && (m_since == 1 || (TAG && m_since == FRAME + 2));
         check($sformatf("rand.c%0d", c),
               32'({req_ready, uart_new_data, uart_data_in, busy, grant_id}),
               32'({exp_ready, exp_nd, m_data, (m_rem > 0), 2'(m_id)}));
         if (rst) begin
            m_rem = 0; m_since = 0; m_ptr = NUM_REQ - 1; m_id = 0; m_data = '0;
         end else if (m_rem == 0) begin
            if (w >= 0) begin
               m_ptr   = w;
               m_id    = w;
               m_since = 1;
               m_rem   = PERIOD - 1;
               m_pay   = 8'(req_data >> (8 * w));
               m_data  = TAG ? {4'hA, 4'(w)} : m_pay;
            end
         end else begin
            m_rem--;
            m_since++;
            if (TAG && m_since == FRAME + 2) m_data = m_pay;
         end
         @(negedge clk);
      end
      rst = 1'b0;
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ byte producers, such as sensor channels and status reporters in the data logger, using round-robin arbitration. The UART gives no busy indication, so the arbiter times each frame itself. It issues a one-cycle new_data pulse with a held data byte, then blocks further grants until the frame plus an inter-frame gap has elapsed. It sits between the logger's sample sources and the uart transmit inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
CLOCK, 50000000, system clock in Hz
BAUD, 9600, line rate
DATA, 8, data bits per frame (must be 8 when the tag feature is enabled)
STOP, 1, stop bits
GAP_CYCLES, 16, idle clock cycles appended after every frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA  packed bytes; requester i uses bits [i*DATA +: DATA]
req_ready  out  NUM_REQ  one-hot accept; transfer happens when valid and ready are both high
uart_new_data  out  1  one-cycle start pulse to the uart new_data input
uart_data_in  out  DATA  byte to the uart data_in input; held stable for the whole frame
busy  out  1  high in any state other than IDLE
grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester

Behaviour:
- Derived constants: BIT_CYCLES = CLOCK/BAUD (integer division). FRAME_CYCLES = BIT_CYCLES*(DATA+1+STOP) + GAP_CYCLES.
- Reset (synchronous, active-high, in effect on the next edge):
  - state goes to IDLE; the frame timer clears.
  - uart_new_data=0, uart_data_in=0, req_ready=0, busy=0, grant_id=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame discards the captured byte. The uart is reset by the same rst, so no partial frame is continued.
- States: IDLE, SEND, FRAME. With the tag feature enabled, TAG_SEND and TAG_FRAME are added.
- IDLE:
  - req_ready is combinational. It is one-hot on the winner: the first valid index searching upward from pointer+1, with wrap-around.
  - On a transfer: req_data[winner] is captured into uart_data_in, grant_id<=winner, pointer<=winner, and state goes to SEND.
  - With no valid request, stay in IDLE and hold all outputs. uart_data_in keeps its last value.
- SEND: uart_new_data=1 for exactly one cycle. Load the timer with FRAME_CYCLES-1, then go to FRAME.
- FRAME:
  - Decrement the timer each cycle. req_ready=0 throughout.
  - At timer==0, go to IDLE.
  - uart_data_in must not change: the uart loads it one cycle after sampling new_data.
- Throughput: back-to-back bytes start every FRAME_CYCLES+2 cycles. Acceptance to the uart_new_data pulse takes 1 cycle.
- Simultaneous requests: only one grant per IDLE visit. Grants rotate strictly, so a continuously valid requester waits at most NUM_REQ-1 frames.
- A requester deasserting valid while not granted loses nothing; no request state is stored.
- A requester changing req_data without a handshake is legal; only the byte present in the accept cycle is sent.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- Enabled: each accepted byte is preceded by a tag frame.
  - Sequence: IDLE accept -> TAG_SEND (uart_data_in = {4'hA, grant_id zero-extended to 4 bits}, new_data pulse) -> TAG_FRAME (full FRAME_CYCLES count) -> SEND with the captured payload byte -> FRAME -> IDLE.
  - The payload is held in a separate register during the tag frame.
  - Back-to-back period becomes 2*(FRAME_CYCLES+1)+1 cycles.
- Disabled: TAG states, the payload register and the tag logic are absent; behaviour is exactly as described above.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum typedef (all five states; TAG states unused when the feature is off);
  - TAG_PREFIX = 4'hA;
  - a constant function frame_cycles(clock, baud, data, stop, gap).
- One sub-module: rr_arbiter. It takes a request vector and pointer, and returns a combinational one-hot grant plus the encoded index. It is parameterised by NUM_REQ and reusable for future shared resources.

Test Plan:
Bench parameters: CLOCK=1000, BAUD=100, DATA=8, STOP=1, GAP_CYCLES=4, NUM_REQ=4, giving BIT_CYCLES=10 and FRAME_CYCLES=104.
1. req_valid=4'b0100, byte 8'h5A, single request -> req_ready=4'b0100 that cycle, uart_new_data pulse 1 cycle later, uart_data_in=8'h5A held 104 cycles, then IDLE and busy=0. A uart loopback model decodes 8'h5A.
2. req_valid=4'b1111 held, bytes 8'h00..8'h03 -> grants in order 0,1,2,3,0 with exactly 106 cycles between accepts.
3. Pointer=1, req_valid=4'b0001 only -> wraps, grants 0, grant_id=0.
4. Assert rst at cycle 50 of FRAME -> next edge gives busy=0, uart_new_data=0, pointer reset. With req_valid=4'b1010 after release, requester 1 is granted first.
5. A requester drops valid while another holds the grant, then reasserts -> no spurious transfer. Its byte is sent on its next turn, with no duplicate.
6. With UART_TX_ARB_TAG_EN, requester 2 sends byte 8'hC3 -> uart sees 8'hA2 and then 8'hC3, new_data pulses 105 cycles apart, and the next accept comes 211 cycles after the first.
